// File: rtl/phasedet_ckratio_pkg.sv
// Shared constants for the integer-ratio phase tracker: FSM encoding and counter width.
package phasedet_ckratio_pkg;

   localparam int unsigned CNTW = 4;

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_CHECK  = 2'd1;
   localparam logic [1:0] ST_LOCK   = 2'd2;

   // Wrapping increment for the good/miss qualification counters.
   function automatic logic [CNTW-1:0] cnt_inc(input logic [CNTW-1:0] c);
      return c + CNTW'(1);
   endfunction

endpackage

// File: rtl/phasedet_satcnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module phasedet_satcnt #(
   parameter int unsigned W = 8
) (
   input  logic         clknx,
   input  logic         rstnx_,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clknx) begin
      if (!rstnx_) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/phasedet_ckratio.sv
// Fast-domain phase tracker for a ratio-locked slow clock: phase index, phase-0 strobe,
// lock qualification, flywheel through isolated glitches, slip detection and error count.
module phasedet_ckratio import phasedet_ckratio_pkg::*; #(
   parameter int unsigned RATIO   = 4,
   parameter int unsigned PW      = 2,
   parameter int unsigned LOCKCNT = 4,
   parameter int unsigned MISSCNT = 3,
   parameter int unsigned ECW     = 8
) (
   input  logic           clknx,
   input  logic           rstnx_,
   input  logic           en,
   input  logic           ckslow,
   input  logic           errclr,
   output logic [PW-1:0]  phase,
   output logic           phase0,
   output logic           locked,
   output logic           slip,
   output logic [ECW-1:0] errcnt
);

   logic [1:0]      state_q,      state_d;
   logic [PW-1:0]   phase_q,      phase_d;
   logic            phase0_q,     phase0_d;
   logic            locked_q,     locked_d;
   logic            slip_q,       slip_d;
   logic [CNTW-1:0] goodcnt_q,    goodcnt_d;
   logic [CNTW-1:0] misscnt_q,    misscnt_d;
   logic            ckslow_dly_q, ckslow_dly_d;

   logic            rise_c;
   logic            exp_c;
   logic            err_inc_c;
   logic [CNTW-1:0] good_inc_c;
   logic [CNTW-1:0] miss_inc_c;

   // Next-state and output decode; phase free-runs unless a branch pins it to 0.
   always_comb begin
      rise_c       = ckslow & ~ckslow_dly_q;
      exp_c        = (phase_q == PW'(RATIO - 1));
      good_inc_c   = cnt_inc(goodcnt_q);
      miss_inc_c   = cnt_inc(misscnt_q);

      state_d      = state_q;
      phase_d      = exp_c ? '0 : phase_q + PW'(1);
      locked_d     = locked_q;
      slip_d       = 1'b0;
      goodcnt_d    = goodcnt_q;
      misscnt_d    = misscnt_q;
      err_inc_c    = 1'b0;
      ckslow_dly_d = ckslow;

      if (!en) begin
         state_d      = ST_SEARCH;
         phase_d      = '0;
         locked_d     = 1'b0;
         goodcnt_d    = '0;
         misscnt_d    = '0;
         ckslow_dly_d = 1'b0;
      end else begin
         case (state_q)
            ST_SEARCH: begin
               phase_d  = '0;
               locked_d = 1'b0;
               if (rise_c) begin
                  state_d   = ST_CHECK;
                  goodcnt_d = '0;
                  misscnt_d = '0;
               end
            end
            ST_CHECK: begin
               locked_d = 1'b0;
               if (rise_c && exp_c) begin
                  goodcnt_d = good_inc_c;
                  if (good_inc_c == CNTW'(LOCKCNT)) begin
                     state_d   = ST_LOCK;
                     locked_d  = 1'b1;
                     goodcnt_d = '0;
                     misscnt_d = '0;
                  end
               end else if (rise_c) begin
                  // Stray edge: realign to it but restart qualification.
                  phase_d   = '0;
                  goodcnt_d = '0;
                  slip_d    = 1'b1;
                  err_inc_c = 1'b1;
               end else if (exp_c) begin
                  state_d   = ST_SEARCH;
                  phase_d   = '0;
                  goodcnt_d = '0;
                  misscnt_d = '0;
                  err_inc_c = 1'b1;
               end
            end
            ST_LOCK: begin
               // Flywheel: bad events are counted but never move the phase.
               if (rise_c && exp_c) begin
                  misscnt_d = '0;
               end else if (rise_c || exp_c) begin
                  err_inc_c = 1'b1;
                  misscnt_d = miss_inc_c;
                  if (miss_inc_c == CNTW'(MISSCNT)) begin
                     state_d   = ST_SEARCH;
                     phase_d   = '0;
                     locked_d  = 1'b0;
                     slip_d    = 1'b1;
                     goodcnt_d = '0;
                     misscnt_d = '0;
                  end
               end
            end
            default: begin
               state_d   = ST_SEARCH;
               phase_d   = '0;
               locked_d  = 1'b0;
               goodcnt_d = '0;
               misscnt_d = '0;
            end
         endcase
      end

      phase0_d = locked_d & (phase_d == '0);
   end

   always_ff @(posedge clknx) begin
      if (!rstnx_) begin
         state_q      <= ST_SEARCH;
         phase_q      <= '0;
         phase0_q     <= 1'b0;
         locked_q     <= 1'b0;
         slip_q       <= 1'b0;
         goodcnt_q    <= '0;
         misscnt_q    <= '0;
         ckslow_dly_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         phase0_q     <= phase0_d;
         locked_q     <= locked_d;
         slip_q       <= slip_d;
         goodcnt_q    <= goodcnt_d;
         misscnt_q    <= misscnt_d;
         ckslow_dly_q <= ckslow_dly_d;
      end
   end

   phasedet_satcnt #(
      .W (ECW)
   ) u_errcnt (
      .clknx  (clknx),
      .rstnx_ (rstnx_),
      .inc    (err_inc_c),
      .clr    (errclr),
      .cnt    (errcnt)
   );

   assign phase  = phase_q;
   assign phase0 = phase0_q;
   assign locked = locked_q;
   assign slip   = slip_q;

endmodule

// File: tb/tb_phasedet_ckratio.sv
// Bench for phasedet_ckratio (RATIO=4): cycle scoreboard fed by a behavioural model,
// plus directed scenario checks against hand-derived constants.
module tb_phasedet_ckratio;

   localparam int unsigned RATIO   = 4;
   localparam int unsigned PW      = 2;
   localparam int unsigned LOCKCNT = 4;
   localparam int unsigned MISSCNT = 3;
   localparam int unsigned ECW     = 8;
   localparam int          ERR_MAX = 255;

   typedef struct packed {
      logic [PW-1:0]  ph;
      logic           p0;
      logic           lk;
      logic           sl;
      logic [ECW-1:0] ec;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           en = 1'b0;
   logic           ckslow = 1'b0;
   logic           errclr = 1'b0;
   logic [PW-1:0]  phase;
   logic           phase0;
   logic           locked;
   logic           slip;
   logic [ECW-1:0] errcnt;

   int checks = 0;
   int failures = 0;

   exp_t sb_q[$];

   // Behavioural reference state
   int m_st = 0;
   int m_ph = 0;
   bit m_lk = 0;
   bit m_sl = 0;
   int m_err = 0;
   int m_good = 0;
   int m_miss = 0;
   bit m_ckd = 0;

   phasedet_ckratio #(
      .RATIO   (RATIO),
      .PW      (PW),
      .LOCKCNT (LOCKCNT),
      .MISSCNT (MISSCNT),
      .ECW     (ECW)
   ) dut (
      .clknx  (clk),
      .rstnx_ (rst_n),
      .en     (en),
      .ckslow (ckslow),
      .errclr (errclr),
      .phase  (phase),
      .phase0 (phase0),
      .locked (locked),
      .slip   (slip),
      .errcnt (errcnt)
   );

   always #5 clk = ~clk;

   // Drive one fast cycle: update the model, push its expectation, then clock.
   task automatic cyc(input logic ck);
      bit rise_m, exp_m, inc;
      int nph;
      exp_t e;
      ckslow = ck;
      if (!rst_n) begin
         m_st = 0; m_ph = 0; m_lk = 0; m_sl = 0; m_err = 0;
         m_good = 0; m_miss = 0; m_ckd = 0;
      end else if (!en) begin
         m_st = 0; m_ph = 0; m_lk = 0; m_sl = 0;
         m_good = 0; m_miss = 0; m_ckd = 0;
         if (errclr) m_err = 0;
      end else begin
         rise_m = ck && !m_ckd;
         exp_m  = (m_ph == RATIO - 1);
         inc    = 0;
         m_sl   = 0;
         nph    = (m_ph + 1) % RATIO;
         if (m_st == 0) begin
            nph = 0;
            if (rise_m) begin m_st = 1; m_good = 0; end
         end else if (m_st == 1) begin
            if (rise_m && exp_m) begin
               m_good++;
               if (m_good == LOCKCNT) begin m_st = 2; m_lk = 1; m_miss = 0; end
            end else if (rise_m) begin
               nph = 0; m_good = 0; m_sl = 1; inc = 1;
            end else if (exp_m) begin
               m_st = 0; nph = 0; inc = 1;
            end
         end else begin
            if (rise_m && exp_m) m_miss = 0;
            else if (rise_m != exp_m) begin
               inc = 1;
               m_miss++;
               if (m_miss == MISSCNT) begin
                  m_st = 0; m_lk = 0; m_sl = 1; nph = 0; m_miss = 0;
               end
            end
         end
         m_ph  = nph;
         m_ckd = ck;
         if (errclr) m_err = 0;
         else if (inc && m_err < ERR_MAX) m_err++;
      end
      e.ph = PW'(m_ph);
      e.p0 = m_lk && (m_ph == 0);
      e.lk = m_lk;
      e.sl = m_sl;
      e.ec = ECW'(m_err);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // One slow period; pulse at cycle pos (pos<0: no pulse).
   task automatic drive_period(input int pos);
      for (int i = 0; i < 4; i++) cyc(i == pos);
   endtask

   task automatic test_reset;
      en = 1; errclr = 0; rst_n = 0;
      cyc(0);
      cyc(1);
      checks++;
      if ({phase, phase0, locked, slip, errcnt} !== '0) begin
         failures++;
         $display("FAIL reset: got ph=%0d p0=%0b lk=%0b sl=%0b ec=%0d, want all 0",
                  phase, phase0, locked, slip, errcnt);
      end
      rst_n = 1;
      cyc(0);
   endtask

   task automatic test_lock;
      int rises = 0;
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < 4; i++) begin
            cyc(i == 0);
            if (i == 0) begin
               rises++;
               checks++;
               if (locked !== (rises >= 5)) begin
                  failures++;
                  $display("FAIL lock_time: rise %0d locked=%0b want %0b", rises, locked, rises >= 5);
               end
            end
            if (p >= 4) begin
               checks++;
               if (phase !== PW'(i) || phase0 !== (i == 0)) begin
                  failures++;
                  $display("FAIL lock_phase: p=%0d i=%0d got ph=%0d p0=%0b", p, i, phase, phase0);
               end
            end
         end
      end
      checks++;
      if (errcnt !== 8'd0) begin
         failures++;
         $display("FAIL lock_err: errcnt=%0d want 0", errcnt);
      end
   endtask

   task automatic test_drop_pulse;
      int exp_ph = 3;
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 4; i++) begin
            cyc(p != 0 && i == 0);
            exp_ph = (exp_ph + 1) % RATIO;
            checks++;
            if (phase !== PW'(exp_ph) || locked !== 1'b1) begin
               failures++;
               $display("FAIL flywheel: p=%0d i=%0d ph=%0d lk=%0b want ph=%0d lk=1",
                        p, i, phase, locked, exp_ph);
            end
         end
      end
      checks++;
      if (errcnt !== 8'd1) begin
         failures++;
         $display("FAIL drop_err: errcnt=%0d want 1", errcnt);
      end
   endtask

   task automatic test_slip_shift;
      int slip_k = -1;
      int rises = 0;
      int k;
      for (int p = 0; p < 12; p++) begin
         for (int i = 0; i < 4; i++) begin
            cyc(i == 1);
            k = p * 4 + i;
            if (slip === 1'b1) begin
               checks++;
               if (slip_k >= 0 || locked !== 1'b0) begin
                  failures++;
                  $display("FAIL slip_pulse: k=%0d first=%0d locked=%0b", k, slip_k, locked);
               end
               if (slip_k < 0) slip_k = k;
            end
            if (slip_k >= 0 && k > slip_k && i == 1) begin
               rises++;
               checks++;
               if (phase !== 2'd0 || locked !== (rises >= 5)) begin
                  failures++;
                  $display("FAIL relock: rise %0d ph=%0d lk=%0b want ph=0 lk=%0b",
                           rises, phase, locked, rises >= 5);
               end
            end
         end
      end
      checks++;
      if (slip_k != 4) begin
         failures++;
         $display("FAIL slip_when: slip at cycle %0d want 4", slip_k);
      end
   endtask

   task automatic test_check_resync;
      rst_n = 0;
      cyc(0);
      rst_n = 1;
      drive_period(0);
      drive_period(0);
      cyc(1);
      cyc(0);
      cyc(1);
      checks++;
      if (slip !== 1'b1 || phase !== 2'd0 || locked !== 1'b0 || errcnt !== 8'd1) begin
         failures++;
         $display("FAIL resync: sl=%0b ph=%0d lk=%0b ec=%0d want 1/0/0/1", slip, phase, locked, errcnt);
      end
      cyc(0);
      checks++;
      if (slip !== 1'b0 || phase !== 2'd1) begin
         failures++;
         $display("FAIL resync_next: sl=%0b ph=%0d want 0/1", slip, phase);
      end
      cyc(0);
      cyc(0);
      for (int q = 0; q < 4; q++) begin
         for (int i = 0; i < 4; i++) begin
            cyc(i == 0);
            if (i == 0) begin
               checks++;
               if (locked !== (q == 3)) begin
                  failures++;
                  $display("FAIL resync_lock: good %0d locked=%0b want %0b", q + 1, locked, q == 3);
               end
            end
         end
      end
   endtask

   task automatic test_enable;
      en = 0;
      cyc(0);
      checks++;
      if (locked !== 1'b0 || phase !== 2'd0 || phase0 !== 1'b0 || errcnt !== 8'd1) begin
         failures++;
         $display("FAIL enable: lk=%0b ph=%0d p0=%0b ec=%0d want 0/0/0/1", locked, phase, phase0, errcnt);
      end
      en = 1;
      cyc(0);
   endtask

   task automatic test_idle;
      rst_n = 0;
      cyc(0);
      rst_n = 1;
      for (int n = 0; n < 40; n++) begin
         cyc(0);
         checks++;
         if ({phase, phase0, locked, slip, errcnt} !== '0) begin
            failures++;
            $display("FAIL idle: n=%0d ph=%0d p0=%0b lk=%0b sl=%0b ec=%0d", n, phase, phase0, locked, slip, errcnt);
         end
      end
   endtask

   task automatic test_err_sat;
      cyc(1);
      for (int n = 0; n < 262; n++) begin
         cyc(0);
         cyc(1);
      end
      checks++;
      if (errcnt !== 8'd255) begin
         failures++;
         $display("FAIL err_sat: errcnt=%0d want 255", errcnt);
      end
      cyc(0);
      cyc(0);
      cyc(0);
      errclr = 1;
      cyc(0);
      errclr = 0;
      checks++;
      if (errcnt !== 8'd0 || locked !== 1'b0) begin
         failures++;
         $display("FAIL clr_wins: errcnt=%0d lk=%0b want 0/0", errcnt, locked);
      end
      for (int p = 0; p < 6; p++) drive_period(0);
      drive_period(-1);
      checks++;
      if (locked !== 1'b1 || errcnt !== 8'd1) begin
         failures++;
         $display("FAIL prereset: lk=%0b ec=%0d want 1/1", locked, errcnt);
      end
      rst_n = 0;
      cyc(1);
      checks++;
      if ({phase, phase0, locked, slip, errcnt} !== '0) begin
         failures++;
         $display("FAIL reset_lock: ph=%0d p0=%0b lk=%0b sl=%0b ec=%0d want all 0",
                  phase, phase0, locked, slip, errcnt);
      end
      rst_n = 1;
      cyc(0);
      cyc(0);
   endtask

   initial begin
      fork
         forever begin
            exp_t e;
            @(negedge clk);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               checks++;
               if ({phase, phase0, locked, slip, errcnt} !== e) begin
                  failures++;
                  $display("FAIL scoreboard t=%0t: got ph=%0d p0=%0b lk=%0b sl=%0b ec=%0d exp ph=%0d p0=%0b lk=%0b sl=%0b ec=%0d",
                           $time, phase, phase0, locked, slip, errcnt, e.ph, e.p0, e.lk, e.sl, e.ec);
               end
            end
         end
      join_none

      test_reset();
      test_lock();
      test_drop_pulse();
      test_slip_shift();
      test_check_resync();
      test_enable();
      test_idle();
      test_err_sat();

      @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: %0d entries left want 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
